// File: rtl/exec_wb_stage.sv
// Execute/write-back stage behind the 32x64 register file.
// Single-cycle ALU ops and an iterative shift-add multiplier drive the write port.
module exec_wb_stage #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [0:WIDTH-1]   data_a,
    input  logic [0:WIDTH-1]   data_b,
    input  logic [AW-1:0]      dst,
    output logic [AW-1:0]      Ad_c,
    output logic [0:WIDTH-1]   data_wr,
    output logic               wr_acc,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [0:WIDTH-1]   mcand_q, mcand_d;
    logic [0:WIDTH-1]   mplier_q, mplier_d;
    logic [0:WIDTH-1]   acc_q, acc_d;
    logic [AW-1:0]      mdst_q, mdst_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      ad_c_q, ad_c_d;
    logic [0:WIDTH-1]   data_wr_q, data_wr_d;
    logic               wr_acc_q, wr_acc_d;
    logic               busy_q, busy_d;

    logic [0:WIDTH-1]   mplier_shift_s;
    logic [0:WIDTH-1]   addend_s;
    logic [0:WIDTH-1]   acc_next_s;

    // Single-cycle result; index 0 is the MSB so $signed sees the correct sign bit.
    function automatic logic [0:WIDTH-1] alu_result(input logic [2:0] f,
                                                    input logic [0:WIDTH-1] a,
                                                    input logic [0:WIDTH-1] b);
        logic [0:WIDTH-1] r;
        case (f)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
            default: r = a;
        endcase
        return r;
    endfunction

    // Partial product for the current multiplier bit (counter counts from the LSB).
    always_comb begin
        mplier_shift_s = mplier_q >> cnt_q;
        if (mplier_shift_s[WIDTH-1]) begin
            addend_s = mcand_q << cnt_q;
        end else begin
            addend_s = '0;
        end
        acc_next_s = acc_q + addend_s;
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        mdst_d    = mdst_q;
        cnt_d     = cnt_q;
        ad_c_d    = ad_c_q;
        data_wr_d = data_wr_q;
        wr_acc_d  = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand_d  = data_a;
                        mplier_d = data_b;
                        mdst_d   = dst;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        wr_acc_d  = 1'b1;
                        ad_c_d    = dst;
                        data_wr_d = alu_result(op, data_a, data_b);
                    end
                end else begin
                    wr_acc_d = 1'b0;
                end
            end
            S_MUL: begin
                acc_d = acc_next_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    wr_acc_d  = 1'b1;
                    ad_c_d    = mdst_q;
                    data_wr_d = acc_next_s;
                    cnt_d     = '0;
                end else begin
                    state_d = S_MUL;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            mdst_q    <= '0;
            cnt_q     <= '0;
            ad_c_q    <= '0;
            data_wr_q <= '0;
            wr_acc_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            mdst_q    <= mdst_d;
            cnt_q     <= cnt_d;
            ad_c_q    <= ad_c_d;
            data_wr_q <= data_wr_d;
            wr_acc_q  <= wr_acc_d;
            busy_q    <= busy_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign Ad_c     = ad_c_q;
    assign data_wr  = data_wr_q;
    assign wr_acc   = wr_acc_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed and randomized bench for exec_wb_stage with a plain-arithmetic reference.
module tb_exec_wb_stage;

    localparam int WIDTH = 64;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [63:0]      data_a;
    logic [63:0]      data_b;
    logic [4:0]       dst;
    logic [4:0]       Ad_c;
    logic [63:0]      data_wr;
    logic             wr_acc;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [4:0]  last_ad   = 5'd0;
    logic [63:0] last_data = 64'd0;

    exec_wb_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .data_a(data_a), .data_b(data_b), .dst(dst),
        .Ad_c(Ad_c), .data_wr(data_wr), .wr_acc(wr_acc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference result straight from the operation definitions.
    function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a,
                                          input logic [63:0] b);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd6:    return a * b;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] d);
        @(negedge clk);
        chk("alu_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; op = f; data_a = a; data_b = b; dst = d;
        tick();
        chk("alu_wr_acc", {63'd0, wr_acc}, 64'd1);
        chk("alu_ad_c", {59'd0, Ad_c}, {59'd0, d});
        chk("alu_data", data_wr, model(f, a, b));
        last_ad = d;
        last_data = model(f, a, b);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom); data_a = {$urandom, $urandom};
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_wr_acc", {63'd0, wr_acc}, 64'd0);
            chk("idle_hold_data", data_wr, last_data);
            chk("idle_hold_ad", {59'd0, Ad_c}, {59'd0, last_ad});
        end
    endtask

    // MUL; when hold=1 the next ALU op is presented throughout the iteration.
    task automatic mul_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d,
                          input bit hold, input logic [2:0] f2, input logic [63:0] a2,
                          input logic [63:0] b2, input logic [4:0] d2);
        @(negedge clk);
        chk("mul_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; op = 3'd6; data_a = a; data_b = b; dst = d;
        for (int i = 0; i < 64; i++) begin
            if (i == 0) begin
                tick();
                @(negedge clk);
                in_valid = hold; op = f2; data_a = a2; data_b = b2; dst = d2;
            end else begin
                tick();
            end
            chk("mul_busy", {63'd0, busy}, 64'd1);
            chk("mul_not_ready", {63'd0, in_ready}, 64'd0);
            chk("mul_no_strobe", {63'd0, wr_acc}, 64'd0);
        end
        tick();
        chk("mul_strobe", {63'd0, wr_acc}, 64'd1);
        chk("mul_product", data_wr, a * b);
        chk("mul_ad_c", {59'd0, Ad_c}, {59'd0, d});
        chk("mul_done_busy", {63'd0, busy}, 64'd0);
        chk("mul_done_ready", {63'd0, in_ready}, 64'd1);
        last_ad = d;
        last_data = a * b;
        if (hold) begin
            tick();
            chk("held_wr_acc", {63'd0, wr_acc}, 64'd1);
            chk("held_data", data_wr, model(f2, a2, b2));
            chk("held_ad_c", {59'd0, Ad_c}, {59'd0, d2});
            last_ad = d2;
            last_data = model(f2, a2, b2);
        end
    endtask

    initial begin
        logic [2:0]  rf;
        logic [63:0] ra;
        logic [63:0] rb;
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; data_a = 64'd0; data_b = 64'd0; dst = 5'd0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wr_acc", {63'd0, wr_acc}, 64'd0);
        chk("rst_ad_c", {59'd0, Ad_c}, 64'd0);
        chk("rst_data", data_wr, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        alu_op(3'd0, 64'd1, 64'd1, 5'd1);
        chk("add_1_1", data_wr, 64'd2);
        idle(2);

        alu_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd2);
        chk("add_wrap", data_wr, 64'd0);
        alu_op(3'd1, 64'd0, 64'd1, 5'd3);
        chk("sub_wrap", data_wr, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);

        mul_op(64'd7, 64'd6, 5'd5, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        chk("mul_42", data_wr, 64'd42);
        idle(2);

        alu_op(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6);
        chk("slt_neg_lt", data_wr, 64'd1);
        alu_op(3'd5, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
        chk("slt_pos_ge", data_wr, 64'd0);
        alu_op(3'd4, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 5'd0);
        chk("xor_self", data_wr, 64'd0);
        alu_op(3'd7, 64'hDEAD_BEEF_0000_0001, 64'd5, 5'd31);
        idle(1);

        // Abort a MUL with reset at iteration 10.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd6; data_a = 64'd3; data_b = 64'd5; dst = 5'd9;
        tick();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_wr_acc", {63'd0, wr_acc}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, in_ready}, 64'd1);
        last_ad = 5'd0;
        last_data = 64'd0;
        idle(70);

        mul_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1'b1,
               3'd0, 64'd100, 64'd23, 5'd12);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            if (rf == 3'd6) begin
                mul_op(ra, rb, 5'($urandom), 1'($urandom), 3'($urandom_range(0, 5)),
                       {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            end else begin
                alu_op(rf, ra, rb, 5'($urandom));
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
